gray_conv_arbiter: RTL and testbench
====================================

# gray_conv_arbiter

Shares one BCD-to-Gray conversion stage between two requesters using round-robin arbitration and valid/ready handshakes on both sides. Each accepted 4-bit BCD digit is converted, tagged with its requester ID and an invalid-BCD flag, and held until the consumer accepts it. An optional timeout drops a result the consumer never accepts. The block sits between the digit producers and the display/encoder path that consumes Gray codes.

## Interface
- TIMEOUT, default 15: cycles a result may wait in PRESENT with out_ready low before it is dropped; 0 disables the timeout.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a digit.
- req0_bcd  input  4  requester 0 digit.
- req0_ready  output  1  requester 0 digit accepted this cycle.
- req1_valid  input  1  requester 1 has a digit.
- req1_bcd  input  4  requester 1 digit.
- req1_ready  output  1  requester 1 digit accepted this cycle.
- out_valid  output  1  result available.
- out_gray  output  4  Gray code of the captured digit.
- out_id  output  1  requester that supplied the digit (0/1).
- out_err  output  1  captured digit was greater than 9.
- out_ready  input  1  consumer accepts the result.
- drop_pulse  output  1  one-cycle pulse when a result is discarded on timeout.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CONV, PRESENT.
- IDLE:
  - Grant is computed combinationally from the valids and the round-robin pointer last_id.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_id is granted.
  - reqN_ready is driven high only for the granted requester, and only while in IDLE with rst low.
  - On a handshake (valid and ready both high) at a rising edge: capture bcd into bcd_r, set id_r and last_id to the granted requester, and go to CONV.
- CONV (exactly one cycle):
  - out_gray <= {b3, b3^b2, b2^b1, b1^b0} from bcd_r.
  - out_err <= (bcd_r > 9). The Gray code is still computed from the raw bits when out_err is set.
  - out_id <= id_r; out_valid <= 1; clear the wait counter; go to PRESENT.
- PRESENT:
  - out_valid, out_gray, out_id and out_err stay stable until the result leaves this state.
  - out_valid and out_ready both high at an edge: out_valid <= 0; go to IDLE.
  - Otherwise, if TIMEOUT != 0, the wait counter increments each cycle. When it reaches TIMEOUT with out_ready still low: out_valid <= 0, drop_pulse <= 1 for one cycle, go to IDLE.
  - If out_ready and the timeout coincide in the same cycle, the handshake wins: no drop.
- Wait counter width is clog2(TIMEOUT+1). The counter saturates and never wraps.
- Requesters are never readied outside IDLE, so a requester holding valid high waits.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE; out_valid, out_gray, out_id, out_err, drop_pulse and busy go to 0.
  - The wait counter clears; last_id goes to 1, so requester 0 wins the first tie.
  - Any in-flight result is lost silently, with no drop_pulse.

## Timing
- Handshake at edge k → CONV during cycle k..k+1 → out_valid high after edge k+1.
- Minimum spacing between accepted digits is 3 edges: IDLE accept, CONV, then PRESENT accepted on its first cycle.
- With TIMEOUT=T and out_ready held low: out_valid rises after edge k+1. It falls, and drop_pulse rises, after edge k+1+T. drop_pulse clears on the next edge.
- reqN_ready is combinational from the valids, state and last_id. There is no combinational path from any input to out_* or drop_pulse.
- busy equals (state != IDLE), registered through the state.

## Test plan
- Reset release, req0_valid=1 with bcd 0111, out_ready=1 → req0_ready high in the first IDLE cycle; two edges later out_valid=1, out_gray=0100, out_id=0, out_err=0; back to IDLE on the next edge.
- Both requesters held valid, req0 digits 0011 and req1 digits 1000, out_ready=1 → grants alternate 0,1,0,1. Outputs are gray 0010/id0 and 1100/id1. Accepts are spaced 3 cycles apart.
- Sweep digits 0–9 on req1 → gray 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101; out_err=0 for all. Digits 1010 and 1111 → gray 1111 and 1000 with out_err=1.
- TIMEOUT=4, out_ready held low → out_valid high for exactly 4 cycles, then one drop_pulse cycle; the next requester is readied in the following IDLE cycle.
- TIMEOUT=4, out_ready raised in the same cycle the counter hits 4 → result accepted, drop_pulse stays 0.
- Assert rst while in PRESENT → all outputs 0 immediately without waiting for a clock, no drop_pulse. After release with both valid, req0 is granted first.

Source files
------------

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter in front of a shared BCD-to-Gray stage; result held until consumed or timed out.
// Latency: accept edge k -> out_valid after edge k+1. Requesters wait (ready low) whenever the stage is not IDLE.
module gray_conv_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_bcd,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_bcd,
  output logic       req1_ready,
  output logic       out_valid,
  output logic [3:0] out_gray,
  output logic       out_id,
  output logic       out_err,
  input  logic       out_ready,
  output logic       drop_pulse,
  output logic       busy
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CONV, PRESENT} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_bcd;
  logic          r_id;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_gnt_vld;
  logic          w_gnt_id;
  logic          w_acc;
  logic          w_out_hs;
  logic          w_timeout;

  // Tie goes to the requester that was not served last.
  assign w_gnt_vld = req0_valid | req1_valid;
  assign w_gnt_id  = (req0_valid & req1_valid) ? ~r_last : req1_valid;
  assign w_acc     = (r_state == IDLE) & w_gnt_vld;
  assign w_out_hs  = out_valid & out_ready;
  assign w_cnt_inc = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CW'(TIMEOUT)) && !out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = CONV;
      CONV:    w_next = PRESENT;
      PRESENT: if (w_out_hs || w_timeout) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (r_state != IDLE);
    if (r_state == IDLE && !rst && w_gnt_vld) begin
      req0_ready = ~w_gnt_id;
      req1_ready = w_gnt_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd      <= 4'd0;
      r_id       <= 1'b0;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      out_valid  <= 1'b0;
      out_gray   <= 4'd0;
      out_id     <= 1'b0;
      out_err    <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_bcd  <= w_gnt_id ? req1_bcd : req0_bcd;
            r_id   <= w_gnt_id;
            r_last <= w_gnt_id;
          end
        end
        CONV: begin
          // Invalid digits still get a Gray code from their raw bits.
          out_gray  <= {r_bcd[3], r_bcd[3] ^ r_bcd[2], r_bcd[2] ^ r_bcd[1], r_bcd[1] ^ r_bcd[0]};
          out_err   <= (r_bcd > 4'd9);
          out_id    <= r_id;
          out_valid <= 1'b1;
          r_cnt     <= '0;
        end
        PRESENT: begin
          if (w_out_hs) begin
            out_valid <= 1'b0;
          end else if (w_timeout) begin
            out_valid  <= 1'b0;
            drop_pulse <= 1'b1;
          end
          r_cnt <= w_cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-timeline reference model.
module tb_gray_conv_arbiter;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] req0_bcd = 4'd0, req1_bcd = 4'd0;
  logic       req0_ready, req1_ready, out_valid, out_id, out_err, drop_pulse, busy;
  logic [3:0] out_gray;

  int checks = 0;
  int errors = 0;

  gray_conv_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_bcd(req0_bcd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_bcd(req1_bcd), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_gray(out_gray), .out_id(out_id), .out_err(out_err),
    .out_ready(out_ready), .drop_pulse(drop_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one result in flight, tracked by edges elapsed since its acceptance.
  bit       m_has, m_last, m_drop, m_id;
  int       m_age;
  bit [3:0] m_bcd;

  function automatic bit [3:0] gray_of(input bit [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic bit pick_id(input bit v0, input bit v1, input bit last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_has = 0; m_age = 0; m_last = 1; m_drop = 0; m_id = 0; m_bcd = 0;
    end else begin
      m_drop = 0;
      if (!m_has) begin
        if (req0_valid || req1_valid) begin
          m_id   = pick_id(req0_valid, req1_valid, m_last);
          m_bcd  = m_id ? req1_bcd : req0_bcd;
          m_last = m_id;
          m_has  = 1;
          m_age  = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (out_ready) begin
        m_has = 0;
      end else if (TO != 0 && m_age == TO) begin
        m_has = 0;
        m_drop = 1;
      end else begin
        m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      automatic bit g  = pick_id(req0_valid, req1_valid, m_last);
      automatic bit gv = !m_has && (req0_valid || req1_valid);
      automatic bit ev = m_has && m_age >= 1;
      chk("req0_ready", req0_ready, gv && !g);
      chk("req1_ready", req1_ready, gv && g);
      chk("out_valid", out_valid, ev);
      chk("busy", busy, m_has);
      chk("drop_pulse", drop_pulse, m_drop);
      if (ev) begin
        chk("out_gray", out_gray, gray_of(m_bcd));
        chk("out_id", out_id, m_id);
        chk("out_err", out_err, m_bcd > 9);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Offer one digit from one requester, check the result against literals, consume it.
  task automatic run_one(input bit id, input bit [3:0] bcd, input bit [3:0] eg, input bit ee);
    int n = 0;
    req0_valid = !id; req1_valid = id; req0_bcd = bcd; req1_bcd = bcd; out_ready = 1;
    #1;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin tick(); n++; end
    if (n >= 20) chk("run_one_accept_timeout", 0, 1);
    tick();
    req0_valid = 0; req1_valid = 0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    chk("run_one_valid", out_valid, 1);
    chk("lit_gray", out_gray, eg);
    chk("lit_err", out_err, ee);
    chk("lit_id", out_id, id);
    tick();
    chk("run_one_consumed", out_valid, 0);
  endtask

  bit [3:0] sweep_g [16];
  bit       ids [4];
  int       times [4];

  initial begin
    int n, cnt, drops, acc, cyc;
    sweep_g = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    repeat (2) tick();

    // First digit after reset: 0111 from requester 0.
    req0_valid = 1; req0_bcd = 4'b0111; out_ready = 1;
    rst = 0;
    #1;
    chk("t1_ready0", req0_ready, 1);
    tick();
    req0_valid = 0;
    chk("t1_busy_conv", busy, 1);
    chk("t1_valid_conv", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_gray", out_gray, 4'b0100);
    chk("t1_id", out_id, 0);
    chk("t1_err", out_err, 0);
    tick();
    chk("t1_idle", busy, 0);

    // Digit sweep on requester 1, including invalid BCD codes.
    for (int d = 0; d < 10; d++) run_one(1, 4'(d), sweep_g[d], 0);
    run_one(1, 4'b1010, 4'b1111, 1);
    run_one(1, 4'b1111, 4'b1000, 1);

    // Timeout with consumer stalled.
    req0_valid = 1; req0_bcd = 4'd5; out_ready = 0;
    tick();
    req0_valid = 0;
    n = 0; while (!out_valid && n < 10) begin tick(); n++; end
    cnt = 0; drops = 0; n = 0;
    while (out_valid && n < 20) begin tick(); cnt++; n++; end
    chk("to_valid_cycles", cnt, TO);
    chk("to_drop", drop_pulse, 1);
    req1_valid = 1; req1_bcd = 4'd2;
    #1;
    chk("to_next_ready", req1_ready, 1);
    tick();
    req1_valid = 0;
    chk("to_drop_clears", drop_pulse, 0);
    n = 0; while (busy && n < 20) begin tick(); n++; end
    out_ready = 1;
    tick();

    // Consumer accepts on the very edge the timeout would fire.
    out_ready = 0;
    req0_valid = 1; req0_bcd = 4'd9;
    tick();
    req0_valid = 0;
    n = 0; while (!out_valid && n < 10) begin tick(); n++; end
    repeat (TO - 1) begin
      if (drop_pulse) drops++;
      tick();
    end
    chk("co_still_valid", out_valid, 1);
    out_ready = 1;
    tick();
    chk("co_accepted", out_valid, 0);
    chk("co_no_drop", drop_pulse | (drops != 0), 0);

    // Asynchronous reset while presenting.
    out_ready = 0;
    req0_valid = 1; req0_bcd = 4'd3;
    tick();
    req0_valid = 0;
    n = 0; while (!out_valid && n < 10) begin tick(); n++; end
    chk("ar_presenting", out_valid, 1);
    #1 rst = 1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_gray", out_gray, 0);
    chk("ar_busy", busy, 0);
    chk("ar_drop", drop_pulse, 0);
    chk("ar_ready0", req0_ready, 0);
    tick();
    req0_valid = 1; req1_valid = 1; req0_bcd = 4'b0011; req1_bcd = 4'b1000; out_ready = 1;
    rst = 0;
    #1;
    chk("ar_tie_ready0", req0_ready, 1);
    chk("ar_tie_ready1", req1_ready, 0);

    // Both requesters held valid: grants alternate, accepts 3 edges apart.
    acc = 0; cyc = 0;
    while (acc < 4 && cyc < 40) begin
      if (req0_ready || req1_ready) begin
        ids[acc] = req1_ready; times[acc] = cyc; acc++;
      end
      if (out_valid) chk("alt_gray", out_gray, out_id ? 4'b1100 : 4'b0010);
      tick(); #1; cyc++;
    end
    chk("alt_count", acc, 4);
    for (int i = 0; i < 4; i++) chk("alt_id", ids[i], i % 2);
    for (int i = 1; i < 4; i++) chk("alt_gap", times[i] - times[i-1], 3);

    // Randomized traffic; stall-heavy segments force timeouts.
    for (int c = 0; c < 3000; c++) begin
      automatic int mode = (c / 300) % 3;
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_bcd   = 4'($urandom);
      req1_bcd   = 4'($urandom);
      out_ready  = (mode == 0) ? ($urandom_range(0, 1) == 1) :
                   (mode == 1) ? ($urandom_range(0, 9) == 0) : 1'b1;
      if (c == 1500) begin
        #1 rst = 1; #1 rst = 0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end
endmodule
